uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 174 +++++++++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver: 2-flop synchronizer, start/data/stop FSM, break handling
//
// Purpose: recovers DATA_BITS-wide LSB-first frames (1 start, DATA_BITS data,
//   1 stop) from an asynchronous idle-high serial line.
// Optional feature macro: UART_RX_MAJORITY_EN. When defined, every sample point
//   is a 2-of-3 vote of rxs at counts mid-1, mid, mid+1. When undefined, a
//   single sample is taken at mid.
// Ports:
//   clk       - single clock for all logic
//   reset     - synchronous active-high reset
//   RxD       - asynchronous serial input, idle high
//   data      - last correctly framed word
//   valid     - one-cycle pulse when data is updated
//   frame_err - one-cycle pulse on a bad (low) stop bit
//   busy      - high whenever the FSM is not in IDLE
module uart_receiver #(
  parameter int CLKS_PER_BIT = 866,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  // With voting, the decision lands one count after the nominal point (after
  // the mid+1 sample). The counter reloads with the same offset so that the
  // bit period stays exactly CLKS_PER_BIT and no drift accumulates.
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_OFS = 1;
`else
  localparam int DEC_OFS = 0;
`endif

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] START_DEC  = CNT_W'(CLKS_PER_BIT / 2 + DEC_OFS);
  localparam logic [CNT_W-1:0] BIT_DEC    = CNT_W'(CLKS_PER_BIT - 1 + DEC_OFS);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEC_OFS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rxs;
  logic                 samp;

  assign rxs        = sync_q[1];
  assign sync_d     = {sync_q[0], RxD};
  assign rxs_prev_d = rxs;

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rxs from the two previous cycles, so at the decision count
  // the vote covers mid-1, mid and mid+1.
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rxs};
  assign samp   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign samp = rxs;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rxs_prev_q && !rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_DEC) begin
          if (!samp) begin
            state_d = S_DATA;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_DEC) begin
          shift_d = DATA_BITS'({samp, shift_q} >> 1);
          cnt_d   = CNT_RELOAD;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_DEC) begin
          cnt_d = '0;
          if (samp) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Line must return high before a new start edge can be seen.
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      rxs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q      <= 2'b11;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxs_prev_q  <= rxs_prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT = 866;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int start_cyc = 0;
  logic [7:0] vdata [0:15];
  int         vcyc  [0:15];
  logic valid_prev = 1'b0;
  logic err_prev = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(BIT), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      vdata[vcnt % 16] = data;
      vcyc[vcnt % 16]  = cyc;
      vcnt = vcnt + 1;
    end
    if (frame_err === 1'b1) ecnt = ecnt + 1;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
    if (valid === 1'b1 && valid_prev === 1'b1) wide_cnt = wide_cnt + 1;
    if (frame_err === 1'b1 && err_prev === 1'b1) wide_cnt = wide_cnt + 1;
    valid_prev = valid;
    err_prev   = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    cycles(n);
  endtask

  // Drives start, 8 data bits LSB first, stop. With glitch set, the line is
  // inverted for one cycle at the single-sample point of each data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit glitch, input int n_cyc);
    logic [9:0] bits;
    int         j;
    int         pos;
    logic       v;
    bits = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int t = 0; t < n_cyc; t++) begin
      j   = t / BIT;
      pos = t % BIT;
      v   = bits[j];
      if (glitch && j >= 1 && j <= 8 && pos == BIT / 2 + 1) v = ~v;
      rxd = v;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int v0;
    int e0;
    int lat;
    logic [7:0] exp96;

    rxd   = 1'b1;
    reset = 1'b1;
    #1;
    cycles(5);
    reset = 1'b0;
    chk("reset_data", data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Clean 0xA5 frame
    idle(20);
    v0 = vcnt; e0 = ecnt;
    send_frame(8'hA5, 1'b1, 1'b0, 10 * BIT);
    idle(20);
    chk("a5_valid_count", vcnt - v0, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_no_frame_err", ecnt - e0, 0);
    chk("a5_busy_idle", busy, 1'b0);
    lat = vcyc[v0 % 16] - start_cyc - 1;
    chk("a5_latency_in_range", (lat >= 8230 && lat <= 8232), 1'b1);

    // 100-cycle low glitch on an idle line
    v0 = vcnt; e0 = ecnt;
    rxd = 1'b0;
    cycles(50);
    chk("glitch_busy_start", busy, 1'b1);
    cycles(50);
    rxd = 1'b1;
    cycles(330);
    chk("glitch_busy_before_mid", busy, 1'b1);
    cycles(10);
    chk("glitch_busy_cleared", busy, 1'b0);
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_frame_err", ecnt - e0, 0);

    // Bad stop bit, long break, then recovery
    idle(20);
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h3C, 1'b0, 1'b0, 10 * BIT);
    rxd = 1'b0;
    cycles(2000);
    chk("break_frame_err_count", ecnt - e0, 1);
    chk("break_no_valid", vcnt - v0, 0);
    chk("break_data_kept", data, 8'hA5);
    chk("break_busy", busy, 1'b1);
    idle(20);
    chk("break_released", busy, 1'b0);
    v0 = vcnt;
    send_frame(8'h55, 1'b1, 1'b0, 10 * BIT);
    idle(20);
    chk("after_break_valid", vcnt - v0, 1);
    chk("after_break_data", data, 8'h55);

    // Back-to-back frames with no idle gap
    v0 = vcnt;
    send_frame(8'h00, 1'b1, 1'b0, 10 * BIT);
    send_frame(8'hFF, 1'b1, 1'b0, 10 * BIT);
    idle(20);
    chk("b2b_valid_count", vcnt - v0, 2);
    chk("b2b_first_data", vdata[v0 % 16], 8'h00);
    chk("b2b_second_data", vdata[(v0 + 1) % 16], 8'hFF);

    // Reset in the middle of data bit 4 of 0x81
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h81, 1'b1, 1'b0, 5 * BIT + 400);
    reset = 1'b1;
    rxd   = 1'b1;
    cycles(10);
    reset = 1'b0;
    chk("midreset_data", data, 8'h00);
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    idle(100);
    chk("midreset_no_valid", vcnt - v0, 0);
    chk("midreset_no_frame_err", ecnt - e0, 0);
    v0 = vcnt;
    send_frame(8'h7E, 1'b1, 1'b0, 10 * BIT);
    idle(20);
    chk("post_reset_valid", vcnt - v0, 1);
    chk("post_reset_data", data, 8'h7E);

    // One-cycle inversion at every data mid-bit point of 0x96
`ifdef UART_RX_MAJORITY_EN
    exp96 = 8'h96;
`else
    exp96 = 8'h69;
`endif
    v0 = vcnt;
    send_frame(8'h96, 1'b1, 1'b1, 10 * BIT);
    idle(20);
    chk("midbit_glitch_valid", vcnt - v0, 1);
    chk("midbit_glitch_data", data, exp96);

    chk("valid_err_overlap", both_cnt, 0);
    chk("pulse_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
